// File: rtl/cal_meas.sv
// Drive-frequency calibration front end: averages 2**LOG2_NPER phase periods and
// captures the peak ADC current over the same window, publishing both with a go strobe.
module cal_meas #(
    parameter int LOG2_NPER = 2,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        phase_in,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    output logic        go,
    output logic [15:0] curr,
    output logic [15:0] per,
    output logic        busy,
    output logic        timeout
);
    localparam int DATA_W = 16;
    localparam int ACC_W  = DATA_W + LOG2_NPER;
    localparam int ECNT_W = LOG2_NPER + 1;
    localparam int NPER   = 1 << LOG2_NPER;
    localparam logic [DATA_W-1:0] TMO       = DATA_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] TMO_M1    = DATA_W'(TIMEOUT - 1);
    localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(NPER - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
    state_t state, state_nxt;

    logic              sync_p0, sync_p1, sync_p2, edge_p3;
    logic [DATA_W-1:0] pcnt;
    logic [DATA_W-1:0] peak;
    logic [ACC_W-1:0]  acc_per;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ECNT_W-1:0] ecnt;
    logic              arm_exp, meas_exp, close;

    function automatic logic [DATA_W-1:0] peak_upd(input logic [DATA_W-1:0] cur,
                                                   input logic              vld,
                                                   input logic [DATA_W-1:0] smp);
        return (vld && (smp > cur)) ? smp : cur;
    endfunction

    function automatic logic [DATA_W-1:0] mean_trunc(input logic [ACC_W-1:0] acc);
        return DATA_W'(acc >> LOG2_NPER);
    endfunction

    // Stage p0..p2: synchroniser plus delay tap; p3: registered rising-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            edge_p3 <= 1'b0;
        end else begin
            sync_p0 <= phase_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= sync_p1 & ~sync_p2;
        end
    end

    assign acc_nxt = acc_per + ACC_W'(pcnt);
    assign busy    = (state != IDLE);
    assign go      = (state == DONE);

    always_comb begin
        state_nxt = state;
        arm_exp   = 1'b0;
        meas_exp  = 1'b0;
        close     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM: begin
                if (edge_p3) begin
                    state_nxt = MEAS;
                end else if (pcnt == TMO_M1) begin
                    arm_exp   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            MEAS: begin
                if (edge_p3) begin
                    if (ecnt == ECNT_LAST) begin
                        close     = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (pcnt == TMO) begin
                    meas_exp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded on the closing edge so they are already valid while go is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pcnt    <= '0;
            peak    <= '0;
            acc_per <= '0;
            ecnt    <= '0;
            per     <= '0;
            curr    <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout <= 1'b0;
                        peak    <= '0;
                        acc_per <= '0;
                        ecnt    <= '0;
                        pcnt    <= '0;
                    end
                end
                ARM: begin
                    pcnt <= edge_p3 ? DATA_W'(1) : pcnt + 1'b1;
                    if (arm_exp) timeout <= 1'b1;
                end
                MEAS: begin
                    peak <= peak_upd(peak, adc_valid, adc_data);
                    if (edge_p3) begin
                        acc_per <= acc_nxt;
                        ecnt    <= ecnt + 1'b1;
                        pcnt    <= DATA_W'(1);
                    end else begin
                        pcnt    <= pcnt + 1'b1;
                    end
                    if (meas_exp) timeout <= 1'b1;
                    if (close) begin
                        per  <= mean_trunc(acc_nxt);
                        curr <= peak_upd(peak, adc_valid, adc_data);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cal_meas.sv
// Bench for cal_meas: directed period/ADC scenarios plus randomized windows,
// checked against a period-list/peak model derived from the phase schedule.
module tb_cal_meas;
    localparam int L2  = 2;
    localparam int TMO = 200;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n, start, phase_in, adc_valid;
    logic [15:0] adc_data;
    logic        go, busy, timeout;
    logic [15:0] curr, per;

    int n_cmp = 0;
    int n_bad = 0;
    int pers[4];
    int exp_per  = 0;
    int exp_curr = 0;

    cal_meas #(.LOG2_NPER(L2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .phase_in(phase_in),
        .adc_valid(adc_valid), .adc_data(adc_data), .go(go), .curr(curr),
        .per(per), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode: 0 random samples, 1 opening/closing boundary pattern, 2 no samples, 3 ramp
    task automatic run_case(input string tag, input bit stuck, input int mode,
                            input bit mid_start, input bit mid_rst);
        int r[5];
        int w[5];
        int s0, sl, ncyc, kres, peak, sum, go_cnt, go_k, val, mid;
        bit abort, vld;
        logic [15:0] per_at_go, curr_at_go;
        r[0] = 10;
        for (int i = 0; i < 4; i++) r[i+1] = r[i] + pers[i];
        for (int i = 0; i < 4; i++) w[i] = pers[i] / 2;
        w[4] = 4;
        s0 = r[0] + LAT;
        sl = r[4] + LAT;
        mid = (s0 + sl) / 2;
        abort = stuck;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += pers[i];
            if (pers[i] > TMO) abort = 1'b1;
        end
        ncyc = stuck ? TMO + 8 : sl + 8;
        kres = mid_rst ? s0 + 150 : -1;
        peak = 0; go_cnt = 0; go_k = -1;
        per_at_go = '0; curr_at_go = '0;
        for (int k = 0; k < ncyc; k++) begin
            start = (k == 0) || (mid_start && (k == s0 + 50 || k == sl + 1));
            phase_in = 1'b0;
            if (!stuck)
                for (int i = 0; i < 5; i++)
                    if (k >= r[i] && k < r[i] + w[i]) phase_in = 1'b1;
            case (mode)
                0: begin vld = 1'($urandom_range(0, 1)); val = int'($urandom_range(0, 65535)); end
                1: begin
                    vld = 1'b1;
                    val = int'($urandom_range(0, 40000));
                    if (k == s0) val = 65000;
                    if (k == sl) val = 50000;
                    if (k == s0 - 1 || k == sl + 1) val = 65535;
                end
                2: begin vld = 1'b0; val = int'($urandom_range(0, 65535)); end
                default: begin
                    vld = 1'b1;
                    val = 61000 - 100 * ((k > mid) ? k - mid : mid - k);
                    if (val < 0) val = 0;
                end
            endcase
            adc_valid = vld;
            adc_data  = 16'(val);
            if (vld && k > s0 && k <= sl && val > peak) peak = val;
            step();
            if (k == kres) begin
                rst_n = 1'b0;
                #1;
                check({tag, "/rst_outputs"}, {go, busy, timeout, curr, per}, 0);
                rst_n = 1'b1;
                exp_per = 0;
                exp_curr = 0;
            end
            if (go) begin
                go_cnt++;
                go_k = k;
                per_at_go = per;
                curr_at_go = curr;
            end
            if (k == 0) begin
                check({tag, "/busy_after_start"}, busy, 1);
                check({tag, "/timeout_cleared"}, timeout, 0);
            end
            if (stuck && k == TMO - 1) check({tag, "/timeout_early"}, {busy, timeout}, 2'b10);
            if (stuck && k == TMO)     check({tag, "/timeout_exact"}, {busy, timeout}, 2'b01);
            if (!stuck && !abort && !mid_rst && k == sl + 1) check({tag, "/busy_after_go"}, busy, 0);
        end
        start = 1'b0;
        if (mid_rst) begin
            check({tag, "/go_count"}, go_cnt, 0);
            check({tag, "/timeout"}, timeout, 0);
        end else if (abort) begin
            check({tag, "/go_count"}, go_cnt, 0);
            check({tag, "/timeout"}, timeout, 1);
        end else begin
            exp_per = sum >> L2;
            exp_curr = peak;
            check({tag, "/go_count"}, go_cnt, 1);
            check({tag, "/go_cycle"}, go_k, sl);
            check({tag, "/per_at_go"}, per_at_go, exp_per);
            check({tag, "/curr_at_go"}, curr_at_go, exp_curr);
            check({tag, "/timeout"}, timeout, 0);
        end
        check({tag, "/per_hold"}, per, exp_per);
        check({tag, "/curr_hold"}, curr, exp_curr);
        check({tag, "/busy_end"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; phase_in = 1'b0; adc_valid = 1'b0; adc_data = '0;
        step();
        step();
        check("reset/go", go, 0);
        check("reset/busy", busy, 0);
        check("reset/timeout", timeout, 0);
        check("reset/curr", curr, 0);
        check("reset/per", per, 0);
        rst_n = 1'b1;
        step();

        pers = '{100, 100, 100, 100};  run_case("square100", 1'b0, 3, 1'b0, 1'b0);
        pers = '{100, 102, 98, 104};   run_case("mean101", 1'b0, 0, 1'b0, 1'b0);
        pers = '{100, 100, 100, 101};  run_case("trunc100", 1'b0, 0, 1'b0, 1'b0);
        pers = '{200, 200, 200, 200};  run_case("at_limit", 1'b0, 0, 1'b0, 1'b0);
        pers = '{100, 201, 100, 100};  run_case("over_limit", 1'b0, 0, 1'b0, 1'b0);
        pers = '{100, 100, 100, 100};  run_case("after_abort", 1'b0, 0, 1'b0, 1'b0);
        run_case("stuck_low", 1'b1, 0, 1'b0, 1'b0);
        pers = '{120, 90, 110, 100};   run_case("after_stuck", 1'b0, 0, 1'b0, 1'b0);
        pers = '{100, 100, 100, 100};  run_case("edge_samples", 1'b0, 1, 1'b0, 1'b0);
        pers = '{100, 100, 100, 100};  run_case("no_samples", 1'b0, 2, 1'b0, 1'b0);
        pers = '{95, 105, 99, 101};    run_case("mid_start", 1'b0, 0, 1'b1, 1'b0);
        pers = '{100, 100, 100, 100};  run_case("mid_reset", 1'b0, 0, 1'b0, 1'b1);
        pers = '{60, 70, 80, 90};      run_case("post_reset", 1'b0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) pers[i] = int'($urandom_range(20, 200));
            if ($urandom_range(0, 3) == 0) pers[$urandom_range(0, 3)] = int'($urandom_range(201, 210));
            run_case($sformatf("rand%0d", t), 1'b0, 0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
